// File: rtl/ascon_bdi_packer_pkg.sv
// +----------------------------------------------------------------------+
// | ascon_bdi_packer_pkg: shared word geometry, segment type codes and   |
// | pack-register state encoding for the Ascon bdi byte packer.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package ascon_bdi_packer_pkg;

    localparam int CCW   = 32;
    localparam int CCWD8 = CCW / 8;

    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_MSG   = 4'h4;
    localparam logic [3:0] D_TAG   = 4'h8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART  = 2'd1,
        FULL  = 2'd2
    } pack_st_t;

endpackage

`default_nettype wire

// File: rtl/ascon_bdi_packer_if.sv
// +----------------------------------------------------------------------+
// | ascon_bdi_packer_if: byte-stream input and packed bdi word output    |
// | of the packer. slave = packer view, master = environment view.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface ascon_bdi_packer_if #(
    parameter int CCW = 32
) ();
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_ready;
    logic [3:0]       s_type;
    logic             s_eot;
    logic             s_eoi;

    logic [CCW-1:0]   bdi;
    logic [CCW/8-1:0] bdi_valid;
    logic             bdi_ready;
    logic [3:0]       bdi_type;
    logic             bdi_eot;
    logic             bdi_eoi;

    modport slave (
        input  s_data, s_valid, s_type, s_eot, s_eoi,
        output s_ready,
        output bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi,
        input  bdi_ready
    );

    modport master (
        output s_data, s_valid, s_type, s_eot, s_eoi,
        input  s_ready,
        input  bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi,
        output bdi_ready
    );
endinterface

`default_nettype wire

// File: rtl/ascon_word_reg.sv
// +----------------------------------------------------------------------+
// | ascon_word_reg: valid/ready output register holding one packed word  |
// | with byte mask, type, eot and eoi. Valid is a non-zero mask.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module ascon_word_reg #(
    parameter int CCW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CCW-1:0]   load_data,
    input  logic [CCW/8-1:0] load_mask,
    input  logic [3:0]       load_type,
    input  logic             load_eot,
    input  logic             load_eoi,
    input  logic             ready,
    output logic             free,
    output logic [CCW-1:0]   data,
    output logic [CCW/8-1:0] mask,
    output logic [3:0]       word_type,
    output logic             eot,
    output logic             eoi
);

    // Free when empty or when the held word is handed off this cycle.
    assign free = ~(|mask) | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            mask      <= '0;
            word_type <= '0;
            eot       <= 1'b0;
            eoi       <= 1'b0;
        end else if (load) begin
            data      <= load_data;
            mask      <= load_mask;
            word_type <= load_type;
            eot       <= load_eot;
            eoi       <= load_eoi;
        end else if ((|mask) && ready) begin
            data      <= '0;
            mask      <= '0;
            word_type <= '0;
            eot       <= 1'b0;
            eoi       <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ascon_bdi_packer.sv
// +----------------------------------------------------------------------+
// | ascon_bdi_packer: packs a typed byte stream into CCW-bit bdi words.  |
// | Optional ASCON_PACKER_CNT_EN adds the 16-bit byte_cnt output.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module ascon_bdi_packer
    import ascon_bdi_packer_pkg::*;
#(
    parameter int CCW = ascon_bdi_packer_pkg::CCW
) (
    input  logic                clk,
    input  logic                rst_n,
    ascon_bdi_packer_if.slave   bus,
`ifdef ASCON_PACKER_CNT_EN
    output logic [15:0]         byte_cnt,
`endif
    output logic                err
);

    localparam int CCWD8 = CCW / 8;
    localparam int CW    = $clog2(CCWD8 + 1);

    pack_st_t         state, state_nx;
    logic [CCW-1:0]   pdata, pdata_nx, wdata, ld_data;
    logic [CW-1:0]    pcnt, pcnt_nx, wcnt, ld_cnt;
    logic [3:0]       ptype, ptype_nx, wtype, ld_type;
    logic             peot, peot_nx, peoi, peoi_nx, ld_eot, ld_eoi;
    logic             err_r, err_nx;
    logic             ld, free, type_chg, accept;
    logic [CCWD8-1:0] ld_mask;

    assign type_chg    = (state == PART) && bus.s_valid && (bus.s_type != ptype);
    assign bus.s_ready = rst_n && (state != FULL) && !type_chg;
    assign accept      = bus.s_valid && bus.s_ready;
    assign err         = err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdata <= '0;
            pcnt  <= '0;
            ptype <= '0;
            peot  <= 1'b0;
            peoi  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            pdata <= pdata_nx;
            pcnt  <= pcnt_nx;
            ptype <= ptype_nx;
            peot  <= peot_nx;
            peoi  <= peoi_nx;
            err_r <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pdata_nx = pdata;
        pcnt_nx  = pcnt;
        ptype_nx = ptype;
        peot_nx  = peot;
        peoi_nx  = peoi;
        err_nx   = err_r;
        ld       = 1'b0;
        ld_data  = pdata;
        ld_cnt   = pcnt;
        ld_type  = ptype;
        ld_eot   = peot;
        ld_eoi   = peoi;
        wdata    = pdata;
        for (int i = 0; i < CCWD8; i++) begin
            if (i == int'(pcnt)) wdata[8*i +: 8] = bus.s_data;
        end
        wcnt  = pcnt + 1'b1;
        wtype = (state == EMPTY) ? bus.s_type : ptype;

        case (state)
            FULL: begin
                if (free) begin
                    ld       = 1'b1;
                    state_nx = EMPTY;
                end
            end
            default: begin
                if (type_chg) begin
                    // Close the held word as end-of-segment; the new-type byte waits a cycle.
                    err_nx  = 1'b1;
                    ld_eot  = 1'b1;
                    ld_eoi  = 1'b0;
                    peot_nx = 1'b1;
                    peoi_nx = 1'b0;
                    if (free) begin
                        ld       = 1'b1;
                        state_nx = EMPTY;
                    end else begin
                        state_nx = FULL;
                    end
                end else if (accept) begin
                    if (bus.s_eoi && !bus.s_eot) err_nx = 1'b1;
                    ld_data  = wdata;
                    ld_cnt   = wcnt;
                    ld_type  = wtype;
                    ld_eot   = bus.s_eot;
                    ld_eoi   = bus.s_eot && bus.s_eoi;
                    pdata_nx = wdata;
                    pcnt_nx  = wcnt;
                    ptype_nx = wtype;
                    peot_nx  = ld_eot;
                    peoi_nx  = ld_eoi;
                    if ((wcnt == CW'(CCWD8)) || bus.s_eot) begin
                        if (free) begin
                            ld       = 1'b1;
                            state_nx = EMPTY;
                        end else begin
                            state_nx = FULL;
                        end
                    end else begin
                        state_nx = PART;
                    end
                end
            end
        endcase

        // Anything handed to the output leaves the pack register clean for the next word.
        if (ld) begin
            pdata_nx = '0;
            pcnt_nx  = '0;
            ptype_nx = '0;
            peot_nx  = 1'b0;
            peoi_nx  = 1'b0;
        end

        for (int i = 0; i < CCWD8; i++) begin
            ld_mask[i] = (i < int'(ld_cnt));
        end
    end

    ascon_word_reg #(.CCW(CCW)) u_word_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld),
        .load_data (ld_data),
        .load_mask (ld_mask),
        .load_type (ld_type),
        .load_eot  (ld_eot),
        .load_eoi  (ld_eoi),
        .ready     (bus.bdi_ready),
        .free      (free),
        .data      (bus.bdi),
        .mask      (bus.bdi_valid),
        .word_type (bus.bdi_type),
        .eot       (bus.bdi_eot),
        .eoi       (bus.bdi_eoi)
    );

`ifdef ASCON_PACKER_CNT_EN
    logic eoi_hs;
    assign eoi_hs = (|bus.bdi_valid) && bus.bdi_ready && bus.bdi_eoi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (eoi_hs) begin
            byte_cnt <= accept ? 16'd1 : 16'd0;
        end else if (accept && (byte_cnt != 16'hFFFF)) begin
            byte_cnt <= byte_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire
